// File: rtl/sim_check_pkg.sv
// Shared types and defaults for the end-of-run checker: FSM state encoding,
// default flag/window constants and the word-count clamp helper.
package sim_check_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [31:0] DEF_END_CODE   = 32'hFFFF_FFFF;
  localparam int unsigned DEF_END_WORD   = 'h3fff;
  localparam int unsigned DEF_TEST_START = 'h2000;

  function automatic int unsigned clamp_num(input int unsigned n, input int unsigned num_max);
    return (n > num_max) ? num_max : n;
  endfunction

endpackage

// File: rtl/end_flag_snoop.sv
// Byte-lane shadow of the end-flag word, built from snooped DM stores, and
// the end-of-run detect derived from it.
module end_flag_snoop #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       END_WORD = sim_check_pkg::DEF_END_WORD,
  parameter logic [DATA_W-1:0] END_CODE = DATA_W'(sim_check_pkg::DEF_END_CODE)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                snoop_en_i,
  input  logic [DATA_W/8-1:0] bus_write_i,
  input  logic [ADDR_W-3:0]   bus_word_i,
  input  logic [DATA_W-1:0]   bus_wdata_i,
  output logic                end_det_o
);

  localparam int unsigned LANES = DATA_W / 8;

  logic [DATA_W-1:0] shadow_q;
  logic              hit;

  assign hit = snoop_en_i && (bus_word_i == (ADDR_W-2)'(END_WORD));

  // Sub-word stores merge lane by lane, so byte and halfword flag writes accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (hit) begin
      for (int b = 0; b < LANES; b++) begin
        // NOTE: non-blocking assignment keeps every lane update tied to the
        // pre-edge value; a blocking write here would create ordering races.
        if (bus_write_i[b]) shadow_q[8*b +: 8] <= bus_wdata_i[8*b +: 8];
      end
    end
  end

  assign end_det_o = (shadow_q == END_CODE);

endmodule

// File: rtl/sim_checker.sv
// End-of-run checker: waits for the end flag or a cycle timeout, then stalls
// the CPU and streams a DM window against a golden source, one word per cycle.
module sim_checker
  import sim_check_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       END_WORD   = DEF_END_WORD,
  parameter logic [DATA_W-1:0] END_CODE   = DATA_W'(DEF_END_CODE),
  parameter int unsigned       TEST_START = DEF_TEST_START,
  parameter int unsigned       NUM_MAX    = 1024,
  parameter int unsigned       MAX_CYCLES = 150000,
  parameter int unsigned       CNT_W      = 32,
  localparam int unsigned      NW_W       = $clog2(NUM_MAX + 1),
  localparam int unsigned      IDX_W      = $clog2(NUM_MAX)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W/8-1:0] bus_write,
  input  logic [ADDR_W-1:0]   bus_addr,
  input  logic [DATA_W-1:0]   bus_wdata,
  input  logic [NW_W-1:0]     num_words,
  output logic [IDX_W-1:0]    gold_addr,
  input  logic [DATA_W-1:0]   gold_data,
  output logic                cpu_hold,
  output logic                chk_read,
  output logic [ADDR_W-1:0]   chk_addr,
  input  logic [DATA_W-1:0]   chk_rdata,
  output logic                err_valid,
  output logic [IDX_W-1:0]    err_idx,
  output logic [DATA_W-1:0]   err_got,
  output logic [DATA_W-1:0]   err_exp,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [CNT_W-1:0]    err_count,
  output logic [IDX_W-1:0]    first_err_idx,
  output logic [CNT_W-1:0]    cycle_count
);

  state_e            state_q;
  logic [NW_W-1:0]   num_q;
  logic [NW_W-1:0]   rd_idx_q;
  logic              cmp_vld_q;
  logic [IDX_W-1:0]  cmp_idx_q;
  logic              cpu_hold_q;
  logic              chk_read_q;
  logic [ADDR_W-1:0] chk_addr_q;
  logic              err_valid_q;
  logic [IDX_W-1:0]  err_idx_q;
  logic [DATA_W-1:0] err_got_q;
  logic [DATA_W-1:0] err_exp_q;
  logic              done_q;
  logic              pass_q;
  logic              timeout_q;
  logic [CNT_W-1:0]  err_count_q;
  logic [IDX_W-1:0]  first_err_idx_q;
  logic [CNT_W-1:0]  cycle_count_q;

  logic              end_det;
  logic              run_exit;
  logic              mismatch;
  logic [NW_W-1:0]   n_clamp;
  logic [NW_W-1:0]   rd_nxt;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^bus_addr[1:0];

  end_flag_snoop #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .END_WORD(END_WORD),
    .END_CODE(END_CODE)
  ) u_snoop (
    .clk        (clk),
    .rst_n      (rst_n),
    .snoop_en_i (state_q == ST_RUN),
    .bus_write_i(bus_write),
    .bus_word_i (bus_addr[ADDR_W-1:2]),
    .bus_wdata_i(bus_wdata),
    .end_det_o  (end_det)
  );

  function automatic logic [ADDR_W-1:0] word_addr(input logic [NW_W-1:0] idx);
    logic [ADDR_W-1:0] w;
    w = ADDR_W'(TEST_START) + ADDR_W'(idx);
    return w << 2;
  endfunction

  assign n_clamp  = NW_W'(clamp_num(32'(num_words), NUM_MAX));
  assign rd_nxt   = rd_idx_q + 1'b1;
  assign run_exit = end_det || (cycle_count_q == CNT_W'(MAX_CYCLES - 1));
  assign mismatch = cmp_vld_q && (chk_rdata != gold_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_RUN;
      num_q           <= '0;
      rd_idx_q        <= '0;
      cmp_vld_q       <= 1'b0;
      cmp_idx_q       <= '0;
      cpu_hold_q      <= 1'b0;
      chk_read_q      <= 1'b0;
      chk_addr_q      <= '0;
      err_valid_q     <= 1'b0;
      err_idx_q       <= '0;
      err_got_q       <= '0;
      err_exp_q       <= '0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      timeout_q       <= 1'b0;
      err_count_q     <= '0;
      first_err_idx_q <= '0;
      cycle_count_q   <= '0;
    end else begin
      err_valid_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (run_exit) begin
            // End detection wins over a coincident timeout.
            timeout_q  <= !end_det;
            state_q    <= ST_CHECK;
            cpu_hold_q <= 1'b1;
            num_q      <= n_clamp;
            rd_idx_q   <= '0;
            chk_read_q <= (n_clamp != '0);
            chk_addr_q <= word_addr('0);
            cmp_vld_q  <= 1'b0;
          end else if (cycle_count_q != CNT_W'(MAX_CYCLES)) begin
            cycle_count_q <= cycle_count_q + 1'b1;
          end
        end

        ST_CHECK: begin
          cmp_vld_q <= chk_read_q;
          cmp_idx_q <= rd_idx_q[IDX_W-1:0];
          if (chk_read_q) begin
            if (rd_nxt == num_q) begin
              chk_read_q <= 1'b0;
            end else begin
              rd_idx_q   <= rd_nxt;
              chk_addr_q <= word_addr(rd_nxt);
            end
          end
          if (mismatch) begin
            err_valid_q <= 1'b1;
            err_idx_q   <= cmp_idx_q;
            err_got_q   <= chk_rdata;
            err_exp_q   <= gold_data;
            if (err_count_q == '0) first_err_idx_q <= cmp_idx_q;
            if (err_count_q != {CNT_W{1'b1}}) err_count_q <= err_count_q + 1'b1;
          end
          // Leave only once the final compare has landed in err_count.
          if (!chk_read_q && !cmp_vld_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            pass_q  <= (err_count_q == '0) && !timeout_q;
          end
        end

        ST_DONE: begin
          state_q <= ST_DONE;
        end

        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign gold_addr     = rd_idx_q[IDX_W-1:0];
  assign cpu_hold      = cpu_hold_q;
  assign chk_read      = chk_read_q;
  assign chk_addr      = chk_addr_q;
  assign err_valid     = err_valid_q;
  assign err_idx       = err_idx_q;
  assign err_got       = err_got_q;
  assign err_exp       = err_exp_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;
  assign cycle_count   = cycle_count_q;

endmodule

// File: tb/tb_sim_checker.sv
// Directed bench for sim_checker: a default instance and a short-timeout
// instance share the snooped bus; each has its own DM/golden read model.
module tb_sim_checker;

  localparam int NUM_MAX = 1024;
  localparam int NW_W    = $clog2(NUM_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_MAX);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0]      bus_write;
  logic [15:0]     bus_addr;
  logic [31:0]     bus_wdata;
  logic [NW_W-1:0] num_words;

  logic [IDX_W-1:0] a_gold_addr, a_err_idx, a_first;
  logic [31:0]      a_gold_data, a_chk_rdata, a_err_got, a_err_exp, a_err_count, a_cycle_count;
  logic [15:0]      a_chk_addr;
  logic             a_cpu_hold, a_chk_read, a_err_valid, a_done, a_pass, a_timeout;

  logic [IDX_W-1:0] t_gold_addr, t_err_idx, t_first;
  logic [31:0]      t_gold_data, t_chk_rdata, t_err_got, t_err_exp, t_err_count, t_cycle_count;
  logic [15:0]      t_chk_addr;
  logic             t_cpu_hold, t_chk_read, t_err_valid, t_done, t_pass, t_timeout;

  logic [31:0] dm   [0:16383];
  logic [31:0] gold [0:NUM_MAX-1];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sim_checker u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .num_words(num_words), .gold_addr(a_gold_addr),
    .gold_data(a_gold_data), .cpu_hold(a_cpu_hold), .chk_read(a_chk_read),
    .chk_addr(a_chk_addr), .chk_rdata(a_chk_rdata), .err_valid(a_err_valid),
    .err_idx(a_err_idx), .err_got(a_err_got), .err_exp(a_err_exp), .done(a_done),
    .pass(a_pass), .timeout(a_timeout), .err_count(a_err_count),
    .first_err_idx(a_first), .cycle_count(a_cycle_count)
  );

  sim_checker #(.MAX_CYCLES(50)) u_dut_t (
    .clk(clk), .rst_n(rst_n), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .num_words(num_words), .gold_addr(t_gold_addr),
    .gold_data(t_gold_data), .cpu_hold(t_cpu_hold), .chk_read(t_chk_read),
    .chk_addr(t_chk_addr), .chk_rdata(t_chk_rdata), .err_valid(t_err_valid),
    .err_idx(t_err_idx), .err_got(t_err_got), .err_exp(t_err_exp), .done(t_done),
    .pass(t_pass), .timeout(t_timeout), .err_count(t_err_count),
    .first_err_idx(t_first), .cycle_count(t_cycle_count)
  );

  always @(posedge clk) begin
    a_chk_rdata <= dm[a_chk_addr[15:2]];
    a_gold_data <= gold[a_gold_addr];
    t_chk_rdata <= dm[t_chk_addr[15:2]];
    t_gold_data <= gold[t_gold_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_write = '0; bus_addr = '0; bus_wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic store(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
    bus_addr = a; bus_write = be; bus_wdata = d;
    tick();
    bus_write = '0; bus_addr = '0; bus_wdata = '0;
  endtask

  task automatic init_mem();
    for (int i = 0; i < NUM_MAX; i++) begin
      gold[i] = 32'h3C5A_0000 + 32'(i) * 32'h0001_0003;
      dm[16'h2000 + i] = gold[i];
    end
  endtask

  initial begin
    bus_write = '0; bus_addr = '0; bus_wdata = '0; num_words = '0;
    for (int i = 0; i < 16384; i++) dm[i] = '0;

    // 1: full-word end flag at cycle 100, four matching words
    init_mem();
    num_words = 4;
    do_reset();
    check("rst_hold", a_cpu_hold, 0);
    check("rst_cycles", a_cycle_count, 0);
    check("rst_done", a_done, 0);
    goto(100);
    store(16'hFFFC, 4'hF, 32'hFFFF_FFFF);
    check("t1_hold_101", a_cpu_hold, 0);
    tick();
    check("t1_hold_102", a_cpu_hold, 1);
    check("t1_read_102", a_chk_read, 1);
    check("t1_addr0", a_chk_addr, 16'h8000);
    check("t1_gold0", a_gold_addr, 0);
    check("t1_cycles", a_cycle_count, 101);
    tick();
    check("t1_addr1", a_chk_addr, 16'h8004);
    check("t1_gold1", a_gold_addr, 1);
    goto(107);
    check("t1_done_107", a_done, 0);
    tick();
    check("t1_done_108", a_done, 1);
    check("t1_pass", a_pass, 1);
    check("t1_errs", a_err_count, 0);
    check("t1_read_off", a_chk_read, 0);
    check("t1_timeout", a_timeout, 0);

    // 2: byte stores accumulate; wrong word and partial flag do not trigger
    init_mem();
    do_reset();
    goto(5);
    store(16'hFFF8, 4'hF, 32'hFFFF_FFFF);
    goto(10);
    for (int b = 0; b < 3; b++) store(16'hFFFC + 16'(b), 4'(1 << b), 32'hFF << (8 * b));
    goto(20);
    check("t2_partial_hold", a_cpu_hold, 0);
    store(16'hFFFF, 4'b1000, 32'hFF00_0000);
    check("t2_hold_21", a_cpu_hold, 0);
    tick();
    check("t2_hold_22", a_cpu_hold, 1);

    // 3: words 2 and 5 corrupted, N=8
    init_mem();
    dm[16'h2002] = gold[2] ^ 32'h0000_0001;
    dm[16'h2005] = gold[5] ^ 32'h8000_0000;
    num_words = 8;
    do_reset();
    goto(10);
    store(16'hFFFC, 4'hF, 32'hFFFF_FFFF);
    goto(12);
    while (cyc <= 21) begin
      check($sformatf("t3_ev_c%0d", cyc), a_err_valid, (cyc == 16 || cyc == 19));
      if (cyc == 16) begin
        check("t3_idx2", a_err_idx, 2);
        check("t3_got2", a_err_got, gold[2] ^ 32'h0000_0001);
        check("t3_exp2", a_err_exp, gold[2]);
      end
      if (cyc == 19) begin
        check("t3_idx5", a_err_idx, 5);
        check("t3_got5", a_err_got, gold[5] ^ 32'h8000_0000);
      end
      check($sformatf("t3_done_c%0d", cyc), a_done, 0);
      tick();
    end
    check("t3_done_22", a_done, 1);
    check("t3_errs", a_err_count, 2);
    check("t3_first", a_first, 2);
    check("t3_pass", a_pass, 0);

    // 4: no end flag, short-timeout instance
    init_mem();
    num_words = 4;
    do_reset();
    goto(49);
    check("t4_to_49", t_timeout, 0);
    check("t4_hold_49", t_cpu_hold, 0);
    tick();
    check("t4_to_50", t_timeout, 1);
    check("t4_hold_50", t_cpu_hold, 1);
    check("t4_cycles", t_cycle_count, 49);
    goto(55);
    check("t4_done_55", t_done, 0);
    tick();
    check("t4_done_56", t_done, 1);
    check("t4_errs", t_err_count, 0);
    check("t4_pass", t_pass, 0);

    // 5: end detected in the timeout cycle, N=0
    init_mem();
    num_words = 0;
    do_reset();
    goto(48);
    store(16'hFFFC, 4'hF, 32'hFFFF_FFFF);
    check("t5_hold_49", t_cpu_hold, 0);
    tick();
    check("t5_hold_50", t_cpu_hold, 1);
    check("t5_to", t_timeout, 0);
    check("t5_read", t_chk_read, 0);
    check("t5_done_50", t_done, 0);
    tick();
    check("t5_done_51", t_done, 1);
    check("t5_pass", t_pass, 1);
    check("t5_errs", t_err_count, 0);

    // 6a: reset at k=3 with later words corrupted
    init_mem();
    dm[16'h2004] = gold[4] ^ 32'h1;
    dm[16'h2005] = gold[5] ^ 32'h1;
    num_words = 8;
    do_reset();
    goto(10);
    store(16'hFFFC, 4'hF, 32'hFFFF_FFFF);
    goto(15);
    check("t6_k3_read", a_chk_read, 1);
    check("t6_k3_gold", a_gold_addr, 3);
    rst_n = 1'b0;
    #1;
    check("t6_async_zero", |{a_gold_addr, a_cpu_hold, a_chk_read, a_chk_addr, a_err_valid,
                             a_err_idx, a_err_got, a_err_exp, a_done, a_pass, a_timeout,
                             a_err_count, a_first, a_cycle_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("t6_no_ev_%0d", i), a_err_valid, 0);
    end
    check("t6_run_hold", a_cpu_hold, 0);
    check("t6_run_errs", a_err_count, 0);

    // 6b: num_words=2000 clamps to 1024; only the last word is corrupted
    init_mem();
    dm[16'h23FF] = gold[1023] ^ 32'h0000_0100;
    num_words = 11'd2000;
    do_reset();
    goto(10);
    store(16'hFFFC, 4'hF, 32'hFFFF_FFFF);
    goto(1037);
    check("t6_done_1037", a_done, 0);
    check("t6_ev_1037", a_err_valid, 1);
    check("t6_idx_1023", a_err_idx, 1023);
    tick();
    check("t6_done_1038", a_done, 1);
    check("t6_errs", a_err_count, 1);
    check("t6_first", a_first, 1023);
    check("t6_pass", a_pass, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
